// File: rtl/addsub_seq_ctrl.sv
// Operand sequencer and result capture stage for the 4-bit add/sub datapath.
// Optional macro ADDSUB_ACCUM_EN: chain operations onto the running result.
module addsub_seq_ctrl #(
  parameter int WIDTH         = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_op,
  input  logic             clear,
  input  logic [WIDTH-1:0] dp_out,
  input  logic             dp_ovf,
  output logic [WIDTH-1:0] opa,
  output logic [WIDTH-1:0] opb,
  output logic             op_sel,
  output logic [WIDTH-1:0] res_data,
  output logic             res_flag,
  output logic             res_valid,
  output logic             busy
);

  // state | meaning
  // IDLE  | waiting for operand A
  // GET_B | A held, waiting for operand B and the operation
  // EXEC  | operands held stable while the settle counter runs down
  // DONE  | result captured, res_valid high for this one cycle
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GET_B = 2'd1;
  localparam logic [1:0] EXEC  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

`ifdef ADDSUB_ACCUM_EN
  localparam logic [1:0] DONE_NEXT = GET_B;
`else
  localparam logic [1:0] DONE_NEXT = IDLE;
`endif

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic [3:0] settle_cnt;
  logic       capture;

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    if (clear) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (in_valid) state_nxt = GET_B;
        GET_B:   if (in_valid) state_nxt = EXEC;
        EXEC: begin
          if (settle_cnt == 4'd0) begin
            state_nxt = DONE;
            capture   = 1'b1;
          end
        end
        DONE:    state_nxt = DONE_NEXT;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      opa        <= '0;
      opb        <= '0;
      op_sel     <= 1'b1;
      settle_cnt <= 4'd0;
      res_data   <= '0;
      res_flag   <= 1'b0;
      res_valid  <= 1'b0;
    end else begin
      state     <= state_nxt;
      busy      <= (state_nxt != IDLE);
      res_valid <= capture;
      // clear leaves operands and the last result untouched
      if (!clear) begin
        case (state)
          IDLE: begin
            if (in_valid) opa <= in_data;
          end
          GET_B: begin
            if (in_valid) begin
              opb        <= in_data;
              op_sel     <= in_op;
              settle_cnt <= SETTLE_LOAD;
            end
          end
          EXEC: begin
            if (settle_cnt != 4'd0) begin
              settle_cnt <= settle_cnt - 4'd1;
            end else begin
              res_data <= dp_out;
              res_flag <= dp_ovf;
            end
          end
`ifdef ADDSUB_ACCUM_EN
          DONE: begin
            opa <= res_data;
          end
`endif
          default: ;
        endcase
      end
    end
  end

endmodule
